// File: rtl/timer_ctrl.sv
// Host-side controller for a byte-wide timer: CLEAR/START/STOP writes and a coherent 4-byte SNAP.
// Optional period compare / auto-clear is compiled in with `define TIMER_CTRL_AUTO_EN.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module timer_ctrl #(
  parameter int AW = `MEM_ADDR_WIDTH,
  parameter int DW = `DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_op,
  output logic          cmd_ready,
  output logic [31:0]   snap,
  output logic          snap_valid,
  output logic          running,
  input  logic          auto_en,
  input  logic [31:0]   period,
  output logic          irq,
  output logic [AW-1:0] t_addr,
  output logic [DW-1:0] t_wdata,
  input  logic [DW-1:0] t_rdata,
  output logic          t_cs_,
  output logic          t_rw_
);

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_SNAP  = 2'd3;

  typedef enum logic [2:0] {IDLE, WR, RD, RESTART, REPORT} state_t;

  state_t      state, state_n;
  logic [1:0]  wr_op;
  logic        seq_snap;
  logic        restart;
  logic [1:0]  byte_cnt;
  logic [31:0] shadow;
  logic        accept;

`ifdef TIMER_CTRL_AUTO_EN
  logic seq_auto;
  logic auto_go;
  logic auto_hit;
`else
  logic seq_auto;
  logic unused_auto;
  assign seq_auto    = 1'b0;
  assign unused_auto = auto_en ^ (|period);
  assign irq         = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
`ifdef TIMER_CTRL_AUTO_EN
    auto_go  = 1'b0;
    auto_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_n = WR;
        end
`ifdef TIMER_CTRL_AUTO_EN
        else if (auto_en && running && period != 32'd0) begin
          auto_go = 1'b1;
          state_n = WR;
        end
`endif
      end
      WR:      state_n = seq_snap ? RD : IDLE;
      RD:      if (byte_cnt == 2'd3) state_n = restart ? RESTART : REPORT;
      RESTART: state_n = REPORT;
      REPORT: begin
        state_n = IDLE;
`ifdef TIMER_CTRL_AUTO_EN
        // Auto compare uses the freshly assembled bytes, not the host-visible snap.
        if (seq_auto && shadow >= period) begin
          auto_hit = 1'b1;
          state_n  = WR;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus drive is purely a function of state so reset idles the bus immediately.
  always_comb begin
    t_cs_   = 1'b1;
    t_rw_   = 1'b1;
    t_addr  = '0;
    t_wdata = '0;
    case (state)
      WR: begin
        t_cs_   = 1'b0;
        t_rw_   = 1'b0;
        t_addr  = AW'(3'd4);
        t_wdata = DW'(3'b001 << wr_op);
      end
      RD: begin
        t_cs_  = 1'b0;
        t_addr = AW'(byte_cnt);
      end
      RESTART: begin
        t_cs_   = 1'b0;
        t_rw_   = 1'b0;
        t_addr  = AW'(3'd4);
        t_wdata = DW'(3'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_op      <= OP_CLEAR;
      seq_snap   <= 1'b0;
      restart    <= 1'b0;
      byte_cnt   <= 2'd0;
      shadow     <= 32'd0;
      snap       <= 32'd0;
      snap_valid <= 1'b0;
      running    <= 1'b0;
    end else begin
      snap_valid <= 1'b0;
      if (accept) begin
        if (cmd_op == OP_SNAP) begin
          wr_op    <= OP_STOP;
          seq_snap <= 1'b1;
          restart  <= running;
        end else begin
          wr_op    <= cmd_op;
          seq_snap <= 1'b0;
        end
      end
`ifdef TIMER_CTRL_AUTO_EN
      if (auto_go) begin
        wr_op    <= OP_STOP;
        seq_snap <= 1'b1;
        restart  <= 1'b1;
      end
      if (auto_hit) begin
        wr_op    <= OP_CLEAR;
        seq_snap <= 1'b0;
      end
`endif
      if (state == WR) begin
        if (wr_op == OP_START)     running <= 1'b1;
        else if (wr_op == OP_STOP) running <= 1'b0;
      end
      if (state == RESTART) running <= 1'b1;
      if (state == RD) begin
        shadow[{byte_cnt, 3'b000} +: 8] <= t_rdata[7:0];
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == REPORT && !seq_auto) begin
        snap       <= shadow;
        snap_valid <= 1'b1;
      end
    end
  end

`ifdef TIMER_CTRL_AUTO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_auto <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= auto_hit;
      if (accept)        seq_auto <= 1'b0;
      else if (auto_go)  seq_auto <= 1'b1;
      else if (auto_hit) seq_auto <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a byte-wide timer model and a snap scoreboard.
module tb_timer_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic          auto_en = 1'b0;
  logic [31:0]   period = 32'd0;
  logic          cmd_ready, snap_valid, running, irq, t_cs_, t_rw_;
  logic [31:0]   snap;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rdata;

  timer_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .snap(snap), .snap_valid(snap_valid), .running(running), .auto_en(auto_en),
    .period(period), .irq(irq), .t_addr(t_addr), .t_wdata(t_wdata), .t_rdata(t_rdata),
    .t_cs_(t_cs_), .t_rw_(t_rw_)
  );

  always #5 clk = ~clk;

  // Timer model: control register at 4 (1 clear, 2 start, 4 stop), count bytes at 0..3.
  logic [31:0] tcnt = 32'd0;
  logic        ten = 1'b0;
  logic        pre_req = 1'b0;
  logic [31:0] pre_val = 32'd0;
  always @(posedge clk) begin
    if (pre_req) tcnt <= pre_val;
    else if (!t_cs_ && !t_rw_ && t_addr == 8'd4) begin
      if (t_wdata == 8'd1) tcnt <= 32'd0;
      if (t_wdata == 8'd2) ten <= 1'b1;
      if (t_wdata == 8'd4) ten <= 1'b0;
    end else if (ten) tcnt <= tcnt + 32'd1;
  end
  always_comb begin
    case (t_addr)
      8'd0:    t_rdata = tcnt[7:0];
      8'd1:    t_rdata = tcnt[15:8];
      8'd2:    t_rdata = tcnt[23:16];
      8'd3:    t_rdata = tcnt[31:24];
      default: t_rdata = 8'd0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int bus_cycles = 0, irq_cnt = 0, sv_cyc = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every snap_valid pulse consumes one expected snap value.
  always @(negedge clk) begin
    if (!t_cs_) bus_cycles++;
    if (irq) irq_cnt++;
    if (snap_valid) begin
      sv_cyc = cyc;
      chk("snap_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("snap", snap, exp_q.pop_front());
    end
  end

  function automatic logic [18:0] bw(input logic sv, input logic cs, input logic rw,
                                     input logic [7:0] a, input logic [7:0] d);
    return {sv, cs, rw, a, d};
  endfunction

  localparam logic [18:0] IDLEW = 19'b1_1000_0000_0000_0000 | 19'(1) << 16;

  task automatic chk_bus(input string tag, input logic [18:0] e);
    @(negedge clk);
    chk(tag, 32'({snap_valid, t_cs_, t_rw_, t_addr, t_wdata}), 32'(e));
  endtask

  task automatic do_cmd(input logic [1:0] op, input bit push, output int acc);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    // A running timer ticks once more on the accept edge before the STOP write freezes it.
    if (push) exp_q.push_back(ten ? tcnt + 32'd1 : tcnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    #1;
    acc       = cyc;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, w, b0;
    logic [18:0] idle_w;
    idle_w = bw(1'b0, 1'b1, 1'b1, 8'd0, 8'd0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_bus", 32'({snap_valid, t_cs_, t_rw_, t_addr, t_wdata}), 32'(idle_w));
    chk("rst_snap", snap, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // CLEAR
    do_cmd(2'd0, 1'b0, acc);
    chk_bus("clear_wr", bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd1));
    chk_bus("clear_done", idle_w);
    chk("clear_running", {31'd0, running}, 32'd0);

    // START, then SNAP while running
    do_cmd(2'd1, 1'b0, acc);
    chk_bus("start_wr", bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd2));
    chk_bus("start_done", idle_w);
    chk("start_running", {31'd0, running}, 32'd1);
    repeat (100) @(posedge clk);
    do_cmd(2'd3, 1'b1, acc);
    chk_bus("snapr_stop", bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd4));
    for (int k = 0; k < 4; k++) chk_bus("snapr_rd", bw(1'b0, 1'b0, 1'b1, 8'(k), 8'd0));
    chk_bus("snapr_restart", bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd2));
    chk_bus("snapr_report", idle_w);
    chk_bus("snapr_valid", bw(1'b1, 1'b1, 1'b1, 8'd0, 8'd0));
    #1;
    chk("snapr_latency", 32'(sv_cyc - acc), 32'd7);
    chk("snapr_range", {31'd0, snap >= 32'd100 && snap <= 32'd110}, 32'd1);
    chk_bus("snapr_pulse_end", idle_w);
    chk("snapr_running", {31'd0, running}, 32'd1);

    // STOP, preload, SNAP while stopped
    do_cmd(2'd2, 1'b0, acc);
    chk_bus("stop_wr", bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd4));
    chk_bus("stop_done", idle_w);
    chk("stop_running", {31'd0, running}, 32'd0);
    @(negedge clk);
    pre_val = 32'h12345678;
    pre_req = 1'b1;
    @(posedge clk);
    #1 pre_req = 1'b0;
    do_cmd(2'd3, 1'b1, acc);
    chk_bus("snaps_stop", bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd4));
    for (int k = 0; k < 4; k++) chk_bus("snaps_rd", bw(1'b0, 1'b0, 1'b1, 8'(k), 8'd0));
    chk_bus("snaps_report", idle_w);
    chk_bus("snaps_valid", bw(1'b1, 1'b1, 1'b1, 8'd0, 8'd0));
    #1;
    chk("snaps_latency", 32'(sv_cyc - acc), 32'd6);
    chk("snaps_value", snap, 32'h12345678);
    chk("snaps_running", {31'd0, running}, 32'd0);

    // CLEAR leaves snap alone
    do_cmd(2'd0, 1'b0, acc);
    chk_bus("clear2_wr", bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd1));
    chk("snap_hold", snap, 32'h12345678);

    // Reset in the middle of the byte reads
    do_cmd(2'd1, 1'b0, acc);
    chk_bus("start2_wr", bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd2));
    do_cmd(2'd3, 1'b0, acc);
    chk_bus("abort_stop", bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd4));
    chk_bus("abort_rd0", bw(1'b0, 1'b0, 1'b1, 8'd0, 8'd0));
    chk_bus("abort_rd1", bw(1'b0, 1'b0, 1'b1, 8'd1, 8'd0));
    chk_bus("abort_rd2", bw(1'b0, 1'b0, 1'b1, 8'd2, 8'd0));
    rst = 1'b1;
    #1;
    chk("abort_bus", 32'({snap_valid, t_cs_, t_rw_, t_addr, t_wdata}), 32'(idle_w));
    chk("abort_snap", snap, 32'd0);
    chk("abort_running", {31'd0, running}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 b0 = bus_cycles;
    @(negedge clk);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (5) @(negedge clk);
    #1 chk("abort_quiet", 32'(bus_cycles - b0), 32'd0);

    // Period compare
    auto_en = 1'b1;
`ifdef TIMER_CTRL_AUTO_EN
    period = 32'd50;
`else
    period = 32'd1;
`endif
    do_cmd(2'd1, 1'b0, acc);
    chk_bus("start3_wr", bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd2));
`ifdef TIMER_CTRL_AUTO_EN
    w = 0;
    while (!irq && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("auto_irq_seen", {31'd0, irq}, 32'd1);
    chk("auto_clear_wr", 32'({snap_valid, t_cs_, t_rw_, t_addr, t_wdata}),
        32'(bw(1'b0, 1'b0, 1'b0, 8'd4, 8'd1)));
    @(negedge clk);
    chk("auto_irq_pulse", {31'd0, irq}, 32'd0);
    auto_en = 1'b0;
    repeat (10) @(negedge clk);
`else
    @(negedge clk);
    #1 b0 = bus_cycles;
    repeat (200) @(negedge clk);
    #1;
    chk("noauto_bus_idle", 32'(bus_cycles - b0), 32'd0);
    chk("noauto_irq", 32'(irq_cnt), 32'd0);
`endif
    chk("snap_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter AW, default `MEM_ADDR_WIDTH, timer bus address width.
REQ-002 SHALL have parameter DW, default `DATA_WIDTH (8), timer bus data width.
REQ-003 SHALL have port clk  in  1  single clock; all state on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1  host command request.
REQ-006 SHALL have port cmd_op  in  2  op: 0 CLEAR, 1 START, 2 STOP, 3 SNAP.
REQ-007 SHALL have port cmd_ready  out  1  high only in IDLE with no auto sequence pending.
REQ-008 SHALL have port snap  out  32  last assembled count.
REQ-009 SHALL have port snap_valid  out  1  one-cycle pulse when snap is updated.
REQ-010 SHALL have port running  out  1  controller's view of timer enable.
REQ-011 SHALL have port auto_en  in  1  enables period compare (macro-gated).
REQ-012 SHALL have port period  in  32  compare value; 0 means compare disabled.
REQ-013 SHALL have port irq  out  1  one-cycle period-match pulse.
REQ-014 SHALL have port t_addr  out  AW  timer address.
REQ-015 SHALL have port t_wdata  out  DW  data to timer.
REQ-016 SHALL have port t_rdata  in  DW  data from timer (combinational on t_addr).
REQ-017 SHALL have ports t_cs_ and t_rw_  out  1 each  active-low select; rw_ low = `Write.

Function
REQ-018 Handshake: command accepted on a posedge with cmd_valid && cmd_ready; cmd_op sampled then.
REQ-019 FSM states: IDLE, WR, RD, RESTART, REPORT.
REQ-020 CLEAR/START/STOP: IDLE->WR; in WR drive t_cs_=0, t_rw_=0, t_addr=4, t_wdata=1/2/4 for exactly one cycle; ->IDLE.
REQ-021 running SHALL set on a START write, clear on a STOP write, unchanged by CLEAR.
REQ-022 SNAP: IDLE->WR (STOP write, 1 cycle)->RD for 4 cycles, t_cs_=0, t_rw_=1, t_addr=0,1,2,3; t_rdata captured each edge into snap bytes [7:0]..[31:24].
REQ-023 After RD byte 3: if running was 1 at accept, ->RESTART (START write, 1 cycle), else skip; ->REPORT.
REQ-024 REPORT: snap registered value presented, snap_valid=1 for one cycle; ->IDLE. Host SNAP latency from accept edge to snap_valid high: 7 cycles running, 6 stopped.
REQ-025 Outside WR/RD/RESTART: t_cs_=1, t_rw_=1, t_addr=0, t_wdata=0.
REQ-026 Timer frozen during SNAP; lost counts (<=6) are accepted behaviour; bytes SHALL be coherent.
REQ-027 Arbitration: host command has priority over auto sequence in same IDLE cycle; cmd_ready=0 during any sequence.
REQ-028 snap holds value between snapshots; not cleared by CLEAR.

Reset
REQ-029 rst high SHALL immediately force IDLE, t_cs_=1, t_rw_=1, t_addr=0, t_wdata=0, snap=0, snap_valid=0, irq=0, running=0, byte counter 0.
REQ-030 Reset mid-sequence SHALL abort with no further bus cycles; timer may remain stopped; host must re-issue START.
REQ-031 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-032 Macro TIMER_CTRL_AUTO_EN defined: when auto_en=1, running=1, period!=0 and state IDLE with no host cmd_valid, controller runs a SNAP sequence internally (no snap_valid pulse); if snap >= period (unsigned), it performs a CLEAR write next cycle and pulses irq on that WR cycle.
REQ-033 Macro undefined: auto_en and period ignored, irq tied 0, no auto sequencing logic.

Verification
REQ-034 Reset then cmd CLEAR -> one cycle t_cs_=0,t_rw_=0,t_addr=4,t_wdata=1; running stays 0.
REQ-035 START, wait 100, SNAP -> STOP write, reads addr 0..3, START write, snap_valid after 7 cycles, snap ~= 101, running=1.
REQ-036 Stopped timer preloaded 0x12345678 model, SNAP -> no RESTART, snap=0x12345678 after 6 cycles.
REQ-037 Assert rst during RD byte 2 -> bus idle next cycle, snap=0, running=0, cmd_ready=1 after release.
REQ-038 AUTO_EN, period=50, START -> irq pulse with CLEAR write once snap>=50; host cmd_valid in same IDLE cycle wins.
REQ-039 Without AUTO_EN, auto_en=1, period=1 -> irq never asserted, bus idle except host commands.
